// File: rtl/edge_event_arbiter.sv
// Rising-edge capture, pending/overflow tracking and round-robin valid/ready event issue.
// Optional EDGE_ARB_BOTH_EDGES_EN: count both edges and report polarity on out_pol.
module edge_event_arbiter #(
   parameter int N_CH = 4,
   parameter int ID_W = 2
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [N_CH-1:0] din,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [ID_W-1:0] out_ch,
   output logic [N_CH-1:0] pending,
   output logic [N_CH-1:0] ovf,
`ifdef EDGE_ARB_BOTH_EDGES_EN
   output logic            out_pol,
`endif
   input  logic [N_CH-1:0] ovf_clr
);

   typedef enum logic {S_IDLE, S_OFFER} state_e;

   state_e            state_q, state_d;
   logic [N_CH-1:0]   din_q;
   logic [N_CH-1:0]   pending_q, pending_d;
   logic [N_CH-1:0]   ovf_q, ovf_d;
   logic              out_valid_q, out_valid_d;
   logic [ID_W-1:0]   out_ch_q, out_ch_d;
   logic [ID_W-1:0]   rr_last_q, rr_last_d;

   logic [N_CH-1:0]   edge_det;
   logic [N_CH-1:0]   grant_vec;
   logic [2*N_CH-1:0] pend_rot;
   logic              handshake, grant_en, win_found;
   logic [ID_W-1:0]   win_idx;
   int                win_off;

`ifdef EDGE_ARB_BOTH_EDGES_EN
   logic [N_CH-1:0]   pol_q, pol_d;
   logic              out_pol_q, out_pol_d;
   assign edge_det = din ^ din_q;
`else
   assign edge_det = din & ~din_q;
`endif

   assign handshake = out_valid_q & out_ready;
   assign grant_en  = (|pending_q) & ((state_q == S_IDLE) | handshake);

   // Rotate so the channel after rr_last lands at bit 0; the lowest set bit wins.
   always_comb begin
      // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
      pend_rot  = {pending_q, pending_q} >> (int'(rr_last_q) + 1);
      win_found = 1'b0;
      win_off   = 0;
      for (int j = N_CH - 1; j >= 0; j--) begin
         if (pend_rot[j]) begin
            win_found = 1'b1;
            win_off   = j;
         end
      end
      win_idx = ID_W'((int'(rr_last_q) + 1 + win_off) % N_CH);
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (|pending_q) state_d = S_OFFER;
         S_OFFER: if (handshake && !(|pending_q)) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Output and per-channel bookkeeping.
   always_comb begin
      out_valid_d = out_valid_q;
      out_ch_d    = out_ch_q;
      rr_last_d   = rr_last_q;
      grant_vec   = '0;
      if (grant_en && win_found) begin
         out_valid_d = 1'b1;
         out_ch_d    = win_idx;
         rr_last_d   = win_idx;
         for (int i = 0; i < N_CH; i++) grant_vec[i] = (win_idx == ID_W'(i));
      end else if (handshake) begin
         out_valid_d = 1'b0;
      end
      // An edge in the grant cycle re-arms the channel; only an unserved repeat overflows.
      pending_d = (pending_q & ~grant_vec) | edge_det;
      ovf_d     = (ovf_q & ~ovf_clr) | (edge_det & pending_q & ~grant_vec);
`ifdef EDGE_ARB_BOTH_EDGES_EN
      pol_d     = (pol_q & ~edge_det) | (din & edge_det);
      out_pol_d = (grant_en && win_found) ? |(pol_q & grant_vec) : out_pol_q;
`endif
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         din_q       <= '0;
         pending_q   <= '0;
         ovf_q       <= '0;
         out_valid_q <= 1'b0;
         out_ch_q    <= '0;
         rr_last_q   <= ID_W'(N_CH - 1);
`ifdef EDGE_ARB_BOTH_EDGES_EN
         pol_q       <= '0;
         out_pol_q   <= 1'b0;
`endif
      end else begin
         // NOTE: non-blocking so every register samples pre-edge values of the others.
         din_q       <= din;
         pending_q   <= pending_d;
         ovf_q       <= ovf_d;
         out_valid_q <= out_valid_d;
         out_ch_q    <= out_ch_d;
         rr_last_q   <= rr_last_d;
`ifdef EDGE_ARB_BOTH_EDGES_EN
         pol_q       <= pol_d;
         out_pol_q   <= out_pol_d;
`endif
      end
   end

   assign out_valid = out_valid_q;
   assign out_ch    = out_ch_q;
   assign pending   = pending_q;
   assign ovf       = ovf_q;
`ifdef EDGE_ARB_BOTH_EDGES_EN
   assign out_pol   = out_pol_q;
`endif

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed scenarios plus randomized traffic against an event-level model of edge_event_arbiter.
module tb_edge_event_arbiter;

   localparam int N  = 4;
   localparam int ID = 2;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [N-1:0]  din = '0;
   logic          out_ready = 1'b0;
   logic [N-1:0]  ovf_clr = '0;
   logic          out_valid;
   logic [ID-1:0] out_ch;
   logic [N-1:0]  pending;
   logic [N-1:0]  ovf;
`ifdef EDGE_ARB_BOTH_EDGES_EN
   logic          out_pol;
`endif

   int n_pass  = 0;
   int n_total = 0;

   // Model state: what the consumer sees and which events are still owed.
   bit [N-1:0] m_din_q, m_pend, m_ovf;
   bit         m_valid;
   int         m_ch, m_last;

   edge_event_arbiter #(.N_CH(N), .ID_W(ID)) dut (
      .clk       (clk),
      .reset     (reset),
      .din       (din),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_ch    (out_ch),
      .pending   (pending),
      .ovf       (ovf),
`ifdef EDGE_ARB_BOTH_EDGES_EN
      .out_pol   (out_pol),
`endif
      .ovf_clr   (ovf_clr)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_din_q = '0;
      m_pend  = '0;
      m_ovf   = '0;
      m_valid = 1'b0;
      m_ch    = 0;
      m_last  = N - 1;
   endtask

   task automatic model_step();
      bit [N-1:0] edges, set_ovf, nxt;
      bit         hs, grant;
      int         w;
      edges = din & ~m_din_q;
      hs    = m_valid && out_ready;
      grant = (m_pend != 0) && (!m_valid || hs);
      w     = -1;
      if (grant) begin
         for (int k = 1; k <= N; k++) begin
            int c;
            c = (m_last + k) % N;
            if (w < 0 && m_pend[c]) w = c;
         end
      end
      nxt     = m_pend;
      set_ovf = '0;
      if (grant) nxt[w] = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (edges[i]) begin
            if (m_pend[i] && !(grant && w == i)) set_ovf[i] = 1'b1;
            nxt[i] = 1'b1;
         end
      end
      m_ovf  = (m_ovf & ~ovf_clr) | set_ovf;
      m_pend = nxt;
      if (grant) begin
         m_valid = 1'b1;
         m_ch    = w;
         m_last  = w;
      end else if (hs) begin
         m_valid = 1'b0;
      end
      m_din_q = din;
   endtask

   task automatic tick();
      if (reset) model_reset();
      else model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic [N-1:0] d, input logic r);
      reset     = 1'b1;
      din       = d;
      out_ready = r;
      ovf_clr   = '0;
      model_reset();
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   // {out_valid, out_ch, pending, ovf}
   function automatic logic [10:0] obs();
      return {out_valid, out_ch, pending, ovf};
   endfunction

   task automatic test_reset();
      do_reset(4'b0001, 1'b0);
      n_total++;
      if (obs() !== 11'b0_00_0000_0000) $display("FAIL reset_state: got %b want %b", obs(), 11'b0_00_0000_0000);
      else n_pass++;
      tick();
      n_total++;
      if (obs() !== 11'b0_00_0001_0000) $display("FAIL reset_first_edge: got %b want %b", obs(), 11'b0_00_0001_0000);
      else n_pass++;
      tick();
      n_total++;
      if (obs() !== 11'b1_00_0000_0000) $display("FAIL reset_first_offer: got %b want %b", obs(), 11'b1_00_0000_0000);
      else n_pass++;
   endtask

   task automatic test_single();
      do_reset(4'b0000, 1'b1);
      tick();
      din = 4'b0100;
      tick();
      n_total++;
      if (obs() !== 11'b0_00_0100_0000) $display("FAIL single_pending: got %b want %b", obs(), 11'b0_00_0100_0000);
      else n_pass++;
      tick();
      n_total++;
      if (obs() !== 11'b1_10_0000_0000) $display("FAIL single_offer: got %b want %b", obs(), 11'b1_10_0000_0000);
      else n_pass++;
      tick();
      n_total++;
      if (obs() !== 11'b0_10_0000_0000) $display("FAIL single_done: got %b want %b", obs(), 11'b0_10_0000_0000);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic [10:0] exp_seq [5];
      exp_seq[0] = 11'b0_00_1011_0000;
      exp_seq[1] = 11'b1_00_1010_0000;
      exp_seq[2] = 11'b1_01_1000_0000;
      exp_seq[3] = 11'b1_11_0000_0000;
      exp_seq[4] = 11'b0_11_0000_0000;
      do_reset(4'b0000, 1'b1);
      din = 4'b1011;
      for (int s = 0; s < 5; s++) begin
         tick();
         n_total++;
         if (obs() !== exp_seq[s]) $display("FAIL b2b_step%0d: got %b want %b", s, obs(), exp_seq[s]);
         else n_pass++;
      end
   endtask

   task automatic test_hold_ovf();
      do_reset(4'b0000, 1'b0);
      din = 4'b0010;
      tick();
      tick();
      n_total++;
      if (obs() !== 11'b1_01_0000_0000) $display("FAIL hold_offer: got %b want %b", obs(), 11'b1_01_0000_0000);
      else n_pass++;
      din = 4'b0000;
      tick();
      n_total++;
      if (obs() !== 11'b1_01_0000_0000) $display("FAIL hold_stable: got %b want %b", obs(), 11'b1_01_0000_0000);
      else n_pass++;
      din = 4'b0010;
      tick();
      n_total++;
      if (obs() !== 11'b1_01_0010_0000) $display("FAIL hold_reedge: got %b want %b", obs(), 11'b1_01_0010_0000);
      else n_pass++;
      din = 4'b0000;
      tick();
      din = 4'b0010;
      tick();
      n_total++;
      if (obs() !== 11'b1_01_0010_0010) $display("FAIL hold_ovf_set: got %b want %b", obs(), 11'b1_01_0010_0010);
      else n_pass++;
      ovf_clr = 4'b0010;
      tick();
      ovf_clr = 4'b0000;
      n_total++;
      if (obs() !== 11'b1_01_0010_0000) $display("FAIL hold_ovf_clr: got %b want %b", obs(), 11'b1_01_0010_0000);
      else n_pass++;
   endtask

   task automatic test_ovf_clr_collision();
      do_reset(4'b0000, 1'b0);
      din = 4'b0100;
      tick();
      tick();
      din = 4'b0000;
      tick();
      din = 4'b0100;
      tick();
      din = 4'b0000;
      tick();
      din     = 4'b0100;
      ovf_clr = 4'b0100;
      tick();
      ovf_clr = 4'b0000;
      n_total++;
      if (obs() !== 11'b1_10_0100_0100) $display("FAIL clr_collision: got %b want %b", obs(), 11'b1_10_0100_0100);
      else n_pass++;
   endtask

   task automatic test_reset_mid_offer();
      do_reset(4'b0000, 1'b0);
      din = 4'b1011;
      tick();
      tick();
      n_total++;
      if (obs() !== 11'b1_00_1010_0000) $display("FAIL midrst_setup: got %b want %b", obs(), 11'b1_00_1010_0000);
      else n_pass++;
      reset = 1'b1;
      #1;
      n_total++;
      if ({out_valid, pending, ovf} !== 9'b0) $display("FAIL midrst_async: got %b want %b", {out_valid, pending, ovf}, 9'b0);
      else n_pass++;
      tick();
      reset = 1'b0;
   endtask

   task automatic test_random();
      logic [10:0] exp_v;
      do_reset(4'b0000, 1'b0);
      for (int c = 0; c < 400; c++) begin
         din       = N'($urandom);
         out_ready = ($urandom % 3) != 0;
         ovf_clr   = (($urandom % 6) == 0) ? N'($urandom) : '0;
         tick();
         exp_v = {m_valid, ID'(m_ch), m_pend, m_ovf};
         n_total++;
         if (obs() !== exp_v) $display("FAIL random_c%0d: got %b want %b", c, obs(), exp_v);
         else n_pass++;
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_hold_ovf();
      test_ovf_clr_collision();
      test_reset_mid_offer();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
